// File: rtl/fetch_queue_pkg.sv
// Shared constants and the buffered-entry layout for the instruction fetch front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_queue_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One buffered fetch: PC in the upper half, instruction word in the lower half.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Generic synchronous FIFO with clear; head is read straight from storage.
// Latency: a push at edge N is visible on head/count from edge N onward.
// Backpressure: none; push when full and pop when empty are ignored, so the caller must respect count.
//
// Ports: clk/reset (async active-low), push/push_data, pop, clear (empties the FIFO,
// overrides push/pop), count (occupancy 0..DEPTH), head (oldest entry, undefined when empty).
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & (count != FULL);
    assign do_pop  = pop & (count != '0);
    assign head    = mem[rd_ptr];

    // Storage is not reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential imem requests, buffers in-order responses with PCs, presents one per cycle.
// Latency: response accepted at edge N is on instr/instr_valid from edge N; request for a redirect target goes out the cycle after redirect.
// Backpressure: requests are credit-limited (queued + in-flight <= DEPTH); stall holds the head; responses are never backpressured.
//
// Ports: clk, reset (async active-low); imem_req_valid/ready/addr request channel;
// imem_rsp_valid/data in-order responses; redirect/redirect_pc from Execute; stall from the
// hazard unit; instr_valid/instr/instr_pc head of queue (NOP and PC 0 when empty).
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] q_count;
    logic [CW-1:0] tag_count;
    logic [31:0]   tag_head;
    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          rsp_keep;
    logic          head_pop;
    fq_entry_t     q_push_dat;
    fq_entry_t     q_head;

    // Stale in-flight requests still hold a credit until their response drains.
    assign credit_used    = {1'b0, q_count} + {1'b0, inflight};
    assign imem_req_valid = reset & ~redirect & (credit_used < CREDITS);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // A live response always has a tag waiting; the tag_count term only guards a protocol violation.
    assign rsp_keep   = imem_rsp_valid & ~redirect & (drop_cnt == '0) & (tag_count != '0);
    assign head_pop   = instr_valid & ~stall & ~redirect;
    assign q_push_dat = '{pc: tag_head, instr: imem_rsp_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else if (redirect) begin
            // Everything still outstanding after this cycle's response belongs to the old path.
            fetch_pc <= redirect_pc;
            inflight <= inflight - CW'(imem_rsp_valid);
            drop_cnt <= inflight - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (rsp_keep),
        .clear     (redirect),
        .count     (tag_count),
        .head      (tag_head)
    );

    sync_fifo #(
        .WIDTH ($bits(fq_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_keep),
        .push_data (q_push_dat),
        .pop       (head_pop),
        .clear     (redirect),
        .count     (q_count),
        .head      (q_head)
    );

    assign instr_valid = (q_count != '0);
    assign instr       = instr_valid ? q_head.instr : NOP_INSTR;
    assign instr_pc    = instr_valid ? q_head.pc    : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Memory model: pending accepted requests with the step index of their response.
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          last_due = 0;
    int          lat = 1;
    bit          lat_rand = 1'b0;

    // Values observed in the step just completed (sampled before the clock edge).
    logic        obs_req_valid, obs_fire, obs_rsp, obs_ivld;
    logic [31:0] obs_addr, obs_instr, obs_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    // One clock step: drive response, sample, take the edge, update memory model.
    task automatic cycle();
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        obs_req_valid = imem_req_valid;
        obs_addr      = imem_req_addr;
        obs_fire      = imem_req_valid & imem_req_ready;
        obs_rsp       = imem_rsp_valid;
        obs_ivld      = instr_valid;
        obs_instr     = instr;
        obs_pc        = instr_pc;
        @(posedge clk);
        cyc++;
        if (obs_rsp) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (obs_fire) begin
            int l;
            int d;
            l = lat_rand ? int'($urandom_range(1, 4)) : lat;
            d = cyc - 1 + l;
            if (d <= last_due) d = last_due + 1;
            pend_addr.push_back(obs_addr);
            pend_due.push_back(d);
            last_due = d;
        end
        @(negedge clk);
    endtask

    task automatic clear_mem();
        pend_addr.delete();
        pend_due.delete();
        last_due = 0;
        imem_rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        redirect = 1'b0;
        stall = 1'b0;
        imem_req_ready = 1'b1;
        lat_rand = 1'b0;
        lat = 1;
        clear_mem();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        total++;
        if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_ivld: got %b want 0", instr_valid); end
        total++;
        if (instr !== NOP) begin bad++; $display("FAIL reset_instr: got %h want %h", instr, NOP); end
        total++;
        if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", instr_pc); end
        total++;
        if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    endtask

    task automatic test_sequential();
        do_reset();
        cycle();
        total++;
        if (!(obs_req_valid === 1'b1 && obs_addr === 32'h0 && obs_ivld === 1'b0)) begin
            bad++; $display("FAIL seq_first_req: got vld=%b addr=%h ivld=%b want 1 0 0", obs_req_valid, obs_addr, obs_ivld);
        end
        cycle();
        total++;
        if (!(obs_fire === 1'b1 && obs_addr === 32'h4 && obs_ivld === 1'b0)) begin
            bad++; $display("FAIL seq_second_req: got fire=%b addr=%h ivld=%b want 1 4 0", obs_fire, obs_addr, obs_ivld);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (!(obs_ivld === 1'b1 && obs_pc === 32'(4 * i) && obs_instr === mem_word(32'(4 * i)))) begin
                bad++; $display("FAIL seq_instr%0d: got v=%b pc=%h i=%h want pc=%h", i, obs_ivld, obs_pc, obs_instr, 4 * i);
            end
        end
    endtask

    task automatic test_stall();
        int nreq;
        do_reset();
        stall = 1'b1;
        nreq = 0;
        repeat (10) begin
            cycle();
            if (obs_fire) nreq++;
        end
        total++;
        if (nreq != 4) begin bad++; $display("FAIL stall_req_count: got %0d want 4", nreq); end
        total++;
        if (obs_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_drop: got %b want 0", obs_req_valid); end
        total++;
        if (!(obs_ivld === 1'b1 && obs_pc === 32'h0)) begin
            bad++; $display("FAIL stall_head: got v=%b pc=%h want 1 0", obs_ivld, obs_pc);
        end
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            total++;
            if (!(obs_ivld === 1'b1 && obs_pc === 32'(4 * i) && obs_instr === mem_word(32'(4 * i)))) begin
                bad++; $display("FAIL stall_drain%0d: got v=%b pc=%h want pc=%h", i, obs_ivld, obs_pc, 4 * i);
            end
        end
    endtask

    task automatic test_redirect_drop();
        bit seen;
        do_reset();
        lat = 3;
        cycle();
        cycle();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        cycle();
        redirect = 1'b0;
        total++;
        if (obs_req_valid !== 1'b0) begin bad++; $display("FAIL rd_no_req: got %b want 0", obs_req_valid); end
        cycle();
        total++;
        if (!(obs_fire === 1'b1 && obs_addr === 32'h100)) begin
            bad++; $display("FAIL rd_target_req: got fire=%b addr=%h want 1 100", obs_fire, obs_addr);
        end
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycle();
            if (obs_ivld) seen = 1'b1;
        end
        total++;
        if (!(seen && obs_pc === 32'h100 && obs_instr === mem_word(32'h100))) begin
            bad++; $display("FAIL rd_first_instr: got seen=%b pc=%h i=%h want pc=100 i=%h", seen, obs_pc, obs_instr, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_collision();
        bit seen;
        do_reset();
        repeat (4) cycle();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        cycle();
        redirect = 1'b0;
        total++;
        if (!(obs_req_valid === 1'b0 && obs_rsp === 1'b1 && obs_ivld === 1'b1)) begin
            bad++; $display("FAIL col_cycle: got reqv=%b rsp=%b ivld=%b want 0 1 1", obs_req_valid, obs_rsp, obs_ivld);
        end
        cycle();
        total++;
        if (!(obs_ivld === 1'b0 && obs_fire === 1'b1 && obs_addr === 32'h200)) begin
            bad++; $display("FAIL col_after: got ivld=%b fire=%b addr=%h want 0 1 200", obs_ivld, obs_fire, obs_addr);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (obs_ivld) seen = 1'b1;
        end
        total++;
        if (!(seen && obs_pc === 32'h200 && obs_instr === mem_word(32'h200))) begin
            bad++; $display("FAIL col_first_instr: got seen=%b pc=%h want 200", seen, obs_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] got[$];
        do_reset();
        cycle();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0;
        for (int i = 0; i < 20 && got.size() < 2; i++) begin
            cycle();
            if (obs_fire) got.push_back(obs_addr);
        end
        total++;
        if (!(got.size() == 2 && got[0] === 32'hFFFF_FFFC && got[1] === 32'h0)) begin
            bad++; $display("FAIL wrap_addrs: got n=%0d first=%h second=%h want fffffffc 00000000",
                            got.size(), (got.size() > 0) ? got[0] : 32'hx, (got.size() > 1) ? got[1] : 32'hx);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        stall = 1'b1;
        repeat (4) cycle();
        #2;
        total++;
        if (!(instr_valid === 1'b1 && instr_pc === 32'h0)) begin
            bad++; $display("FAIL ar_pre: got v=%b pc=%h want 1 0", instr_valid, instr_pc);
        end
        reset = 1'b0;
        #1;
        total++;
        if (!(instr_valid === 1'b0 && instr === NOP && instr_pc === 32'h0 && imem_req_valid === 1'b0)) begin
            bad++; $display("FAIL ar_outputs: got v=%b i=%h pc=%h reqv=%b want 0 %h 0 0", instr_valid, instr, instr_pc, imem_req_valid, NOP);
        end
        clear_mem();
        stall = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        cycle();
        total++;
        if (!(obs_fire === 1'b1 && obs_addr === 32'h0)) begin
            bad++; $display("FAIL ar_restart_req: got fire=%b addr=%h want 1 0", obs_fire, obs_addr);
        end
        cycle();
        cycle();
        total++;
        if (!(obs_ivld === 1'b1 && obs_pc === 32'h0 && obs_instr === mem_word(32'h0))) begin
            bad++; $display("FAIL ar_restart_instr: got v=%b pc=%h want 1 0", obs_ivld, obs_pc);
        end
    endtask

    // Program-order model: consumed PCs run sequentially from the last reset/redirect target,
    // each carrying the word memory holds at that address; requests also run sequentially.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] exp_req;
        logic [31:0] rp;
        int          pops;
        int          errs;
        do_reset();
        lat_rand = 1'b1;
        exp_pc = 32'h0;
        exp_req = 32'h0;
        pops = 0;
        errs = 0;
        for (int i = 0; i < 800; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 24) == 0);
            rp = $urandom;
            rp[1:0] = 2'b00;
            redirect_pc = rp;
            cycle();
            if (redirect) begin
                total++;
                if (obs_req_valid !== 1'b0) begin
                    bad++; errs++;
                    if (errs < 10) $display("FAIL rnd_redirect_req: cyc=%0d got %b want 0", cyc, obs_req_valid);
                end
                exp_pc = rp;
                exp_req = rp;
            end else begin
                if (obs_fire) begin
                    total++;
                    if (obs_addr !== exp_req) begin
                        bad++; errs++;
                        if (errs < 10) $display("FAIL rnd_req_addr: cyc=%0d got %h want %h", cyc, obs_addr, exp_req);
                    end
                    exp_req = exp_req + 32'd4;
                end
                if (obs_ivld && !stall) begin
                    total++;
                    if (obs_pc !== exp_pc || obs_instr !== mem_word(exp_pc)) begin
                        bad++; errs++;
                        if (errs < 10) $display("FAIL rnd_pop: cyc=%0d got pc=%h i=%h want pc=%h i=%h",
                                                cyc, obs_pc, obs_instr, exp_pc, mem_word(exp_pc));
                    end
                    exp_pc = exp_pc + 32'd4;
                    pops++;
                end
            end
            if (!obs_ivld) begin
                total++;
                if (obs_instr !== NOP || obs_pc !== 32'h0) begin
                    bad++; errs++;
                    if (errs < 10) $display("FAIL rnd_empty: cyc=%0d got i=%h pc=%h want %h 0", cyc, obs_instr, obs_pc, NOP);
                end
            end
            total++;
            if (pend_addr.size() > 4) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rnd_inflight: cyc=%0d got %0d want <=4", cyc, pend_addr.size());
            end
        end
        redirect = 1'b0;
        stall = 1'b0;
        total++;
        if (pops < 150) begin bad++; $display("FAIL rnd_throughput: got %0d pops want >=150", pops); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_drop();
        test_redirect_collision();
        test_wrap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
